vx_vec_operand_sink: RTL and testbench

- Receiving end of the operand dispatch channel, sitting at the ingress of a vector-capable execute unit.
- Accepts operand beats through a 2-entry buffer and forwards them to the execute datapath in order.
- Tracks per-issue-slot vector lane sequences, checks the vd_lane_id/vd_is_last protocol, and emits one commit record per completed vector instruction.

---
 rtl/vx_vec_operand_sink.sv | 210 +++++++++++++++++++++
 tb/tb_vx_vec_operand_sink.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_vec_operand_sink.sv
// Operand dispatch sink: 2-entry ingress buffer feeding the execute datapath,
// with per-slot vector lane sequencing, commit records and error reporting.
module vx_vec_operand_sink #(
  parameter int unsigned NUM_WIS   = 4,
  parameter int unsigned MAX_LANES = 8,
  parameter int unsigned NR_BITS   = 6,
  parameter int unsigned PAYLOAD_W = 256,
  localparam int unsigned WIS_W    = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1,
  localparam int unsigned LANE_W   = $clog2(MAX_LANES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIS_W-1:0]     in_wis,
  input  logic                 in_is_vec,
  input  logic [NR_BITS-1:0]   in_vd,
  input  logic [NR_BITS-1:0]   in_vd_lane_id,
  input  logic                 in_vd_is_last,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIS_W-1:0]     out_wis,
  output logic                 out_is_vec,
  output logic [LANE_W-1:0]    out_lane_id,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 cmt_valid,
  input  logic                 cmt_ready,
  output logic [WIS_W-1:0]     cmt_wis,
  output logic [NR_BITS-1:0]   cmt_vd,
  output logic [LANE_W:0]      cmt_lanes,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [WIS_W-1:0]     err_wis,
  output logic                 err_sticky
);

  localparam int unsigned CNT_W = LANE_W + 1;
  localparam int unsigned DEPTH = 2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_LANE = 2'd1;
  localparam logic [1:0] ERR_SCALAR   = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef struct packed {
    logic [WIS_W-1:0]     wis;
    logic                 is_vec;
    logic [NR_BITS-1:0]   vd;
    logic [NR_BITS-1:0]   lane;
    logic                 is_last;
    logic [PAYLOAD_W-1:0] payload;
  } beat_t;

  beat_t              fifo_mem [DEPTH];
  beat_t              head;
  beat_t              beat_in;
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic [1:0]         count_nxt;
  logic               push;
  logic               fire;
  logic               head_stall;

  logic               act      [NUM_WIS];
  logic [CNT_W-1:0]   exp_lane [NUM_WIS];
  logic [NR_BITS-1:0] vd_q     [NUM_WIS];
  logic [CNT_W-1:0]   cnt      [NUM_WIS];

  logic [WIS_W-1:0]   slot;
  logic               lane_ovf;
  logic               seq_upd;
  logic               nxt_act;
  logic [CNT_W-1:0]   nxt_exp;
  logic [NR_BITS-1:0] nxt_vd;
  logic [CNT_W-1:0]   nxt_cnt;
  logic               ovf;
  logic               bad;
  logic               scalar_err;
  logic               err_set;
  logic [1:0]         err_code_nxt;
  logic               cmt_load;

  always_comb begin
    beat_in.wis     = in_wis;
    beat_in.is_vec  = in_is_vec;
    beat_in.vd      = in_vd;
    beat_in.lane    = in_vd_lane_id;
    beat_in.is_last = in_vd_is_last;
    beat_in.payload = in_payload;
  end

  // A last beat cannot leave while the previous commit is still stuck.
  assign head       = fifo_mem[rd_ptr];
  assign head_stall = head.is_vec && head.is_last && cmt_valid && !cmt_ready;
  assign out_valid  = (count != 2'd0) && !head_stall;
  assign push       = in_valid && in_ready;
  assign fire       = out_valid && out_ready;
  assign count_nxt  = 2'(count + 2'(push) - 2'(fire));

  assign out_wis     = head.wis;
  assign out_is_vec  = head.is_vec;
  assign out_lane_id = head.lane[LANE_W-1:0];
  assign out_payload = head.payload;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= beat_in;
        wr_ptr           <= ~wr_ptr;
      end
      if (fire) rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      in_ready <= count_nxt < 2'(DEPTH);
    end
  end

  // Sequence checking on the fired head beat; state follows output order.
  always_comb begin
    slot       = head.wis;
    lane_ovf   = head.lane >= NR_BITS'(MAX_LANES);
    seq_upd    = 1'b0;
    nxt_act    = act[slot];
    nxt_exp    = exp_lane[slot];
    nxt_vd     = vd_q[slot];
    nxt_cnt    = cnt[slot];
    ovf        = 1'b0;
    bad        = 1'b0;
    scalar_err = 1'b0;
    cmt_load   = 1'b0;
    if (fire && head.is_vec) begin
      seq_upd = 1'b1;
      if (!act[slot]) begin
        ovf     = lane_ovf;
        bad     = head.lane != '0;
        nxt_vd  = head.vd;
        nxt_cnt = CNT_W'(1);
      end else begin
        ovf     = lane_ovf || (cnt[slot] >= CNT_W'(MAX_LANES));
        bad     = (head.lane != NR_BITS'(exp_lane[slot])) || (head.vd != vd_q[slot]);
        nxt_cnt = (cnt[slot] >= CNT_W'(MAX_LANES)) ? CNT_W'(MAX_LANES)
                                                   : CNT_W'(cnt[slot] + CNT_W'(1));
      end
      nxt_exp  = CNT_W'(head.lane + NR_BITS'(1));
      nxt_act  = !head.is_last;
      cmt_load = head.is_last;
    end else if (fire && act[slot]) begin
      scalar_err = 1'b1;
    end
    err_set      = ovf | bad | scalar_err;
    err_code_nxt = ovf        ? ERR_OVERFLOW :
                   bad        ? ERR_BAD_LANE :
                   scalar_err ? ERR_SCALAR   : ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WIS; i++) begin
        act[i]      <= 1'b0;
        exp_lane[i] <= '0;
        vd_q[i]     <= '0;
        cnt[i]      <= '0;
      end
    end else if (seq_upd) begin
      act[slot]      <= nxt_act;
      exp_lane[slot] <= nxt_exp;
      vd_q[slot]     <= nxt_vd;
      cnt[slot]      <= nxt_cnt;
    end
  end

  // Commit record: a new load wins over a same-cycle drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmt_valid <= 1'b0;
      cmt_wis   <= '0;
      cmt_vd    <= '0;
      cmt_lanes <= '0;
    end else if (cmt_load) begin
      cmt_valid <= 1'b1;
      cmt_wis   <= slot;
      cmt_vd    <= nxt_vd;
      cmt_lanes <= nxt_cnt;
    end else if (cmt_ready) begin
      cmt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid  <= 1'b0;
      err_code   <= ERR_NONE;
      err_wis    <= '0;
      err_sticky <= 1'b0;
    end else begin
      err_valid  <= err_set;
      err_code   <= err_set ? err_code_nxt : ERR_NONE;
      err_wis    <= err_set ? slot : '0;
      err_sticky <= err_sticky | err_set;
    end
  end

endmodule

// File: tb/tb_vx_vec_operand_sink.sv
// Bench for vx_vec_operand_sink: directed scenarios plus random traffic, all
// checked every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_vx_vec_operand_sink;
  localparam int NUM_WIS   = 4;
  localparam int MAX_LANES = 8;
  localparam int NR_BITS   = 6;
  localparam int PAYLOAD_W = 256;
  localparam int WIS_W     = 2;
  localparam int LANE_W    = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIS_W-1:0]     in_wis = '0;
  logic                 in_is_vec = 1'b0;
  logic [NR_BITS-1:0]   in_vd = '0;
  logic [NR_BITS-1:0]   in_vd_lane_id = '0;
  logic                 in_vd_is_last = 1'b0;
  logic [PAYLOAD_W-1:0] in_payload = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [WIS_W-1:0]     out_wis;
  logic                 out_is_vec;
  logic [LANE_W-1:0]    out_lane_id;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 cmt_valid;
  logic                 cmt_ready = 1'b0;
  logic [WIS_W-1:0]     cmt_wis;
  logic [NR_BITS-1:0]   cmt_vd;
  logic [LANE_W:0]      cmt_lanes;
  logic                 err_valid;
  logic [1:0]           err_code;
  logic [WIS_W-1:0]     err_wis;
  logic                 err_sticky;

  always #5 clk = ~clk;

  vx_vec_operand_sink dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wis(in_wis), .in_is_vec(in_is_vec),
    .in_vd(in_vd), .in_vd_lane_id(in_vd_lane_id), .in_vd_is_last(in_vd_is_last),
    .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_wis(out_wis), .out_is_vec(out_is_vec),
    .out_lane_id(out_lane_id), .out_payload(out_payload),
    .cmt_valid(cmt_valid), .cmt_ready(cmt_ready), .cmt_wis(cmt_wis), .cmt_vd(cmt_vd),
    .cmt_lanes(cmt_lanes),
    .err_valid(err_valid), .err_code(err_code), .err_wis(err_wis), .err_sticky(err_sticky)
  );

  typedef struct {
    int           wis;
    bit           is_vec;
    int           vd;
    int           lane;
    bit           last;
    logic [255:0] payload;
  } beat_t;
  typedef struct { int wis; int vd; int lanes; } cmt_t;
  typedef struct { int code; int wis; } err_t;

  beat_t        src[$];
  beat_t        q[$];
  cmt_t         cmt_log[$];
  err_t         err_log[$];
  logic [255:0] fired_pl[$];
  int           fired;
  bit           m_act [NUM_WIS];
  int           m_exp [NUM_WIS];
  int           m_vd  [NUM_WIS];
  int           m_cnt [NUM_WIS];
  bit           m_cmt_v;
  cmt_t         m_cmt;
  bit           m_err_v;
  err_t         m_err;
  bit           m_sticky;
  bit           exp_ov;
  bit           chk_en = 1'b0;
  int           total = 0;
  int           bad = 0;
  int           in_pct = 100;
  int           or_pct = 100;
  int           cr_pct = 100;
  bit           rst_req = 1'b1;
  int           g_next [NUM_WIS];
  int           g_len  [NUM_WIS];
  int           g_vd   [NUM_WIS];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd_pl();
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic beat_t vbeat(input int w, input int vd, input int lane, input bit last);
    beat_t b;
    b.wis = w; b.is_vec = 1'b1; b.vd = vd; b.lane = lane; b.last = last; b.payload = rnd_pl();
    return b;
  endfunction

  function automatic beat_t sbeat(input int w);
    beat_t b;
    b.wis = w; b.is_vec = 1'b0; b.vd = int'($urandom_range(63)); b.lane = int'($urandom_range(15));
    b.last = 1'b0; b.payload = rnd_pl();
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NUM_WIS; i++) begin
      m_act[i] = 1'b0; m_exp[i] = 0; m_vd[i] = 0; m_cnt[i] = 0;
    end
    m_cmt_v = 1'b0; m_err_v = 1'b0; m_sticky = 1'b0;
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      chk("out_wis", out_wis, q[0].wis);
      chk("out_is_vec", out_is_vec, q[0].is_vec);
      chk("out_lane_id", out_lane_id, q[0].lane % MAX_LANES);
      chk("out_payload", out_payload, q[0].payload);
    end
    chk("cmt_valid", cmt_valid, m_cmt_v);
    if (m_cmt_v) begin
      chk("cmt_wis", cmt_wis, m_cmt.wis);
      chk("cmt_vd", cmt_vd, m_cmt.vd);
      chk("cmt_lanes", cmt_lanes, m_cmt.lanes);
    end
    chk("err_valid", err_valid, m_err_v);
    if (m_err_v) begin
      chk("err_code", err_code, m_err.code);
      chk("err_wis", err_wis, m_err.wis);
    end
    chk("err_sticky", err_sticky, m_sticky);
  endtask

  // One clock: drive at negedge, compare, then advance the model across the posedge.
  task automatic step();
    beat_t cur;
    beat_t h;
    bit    push, fire, load, ovf, bd;
    int    w, code;
    @(negedge clk);
    reset = rst_req;
    if (src.size() > 0 && int'($urandom_range(99)) < in_pct) begin
      cur = src[0]; in_valid = 1'b1;
    end else begin
      cur = sbeat(int'($urandom_range(3))); in_valid = 1'b0;
    end
    in_wis        = WIS_W'(cur.wis);
    in_is_vec     = cur.is_vec;
    in_vd         = NR_BITS'(cur.vd);
    in_vd_lane_id = NR_BITS'(cur.lane);
    in_vd_is_last = cur.last;
    in_payload    = cur.payload;
    out_ready     = int'($urandom_range(99)) < or_pct;
    cmt_ready     = int'($urandom_range(99)) < cr_pct;
    #1;
    exp_ov = q.size() > 0 && !(q[0].is_vec && q[0].last && m_cmt_v && !cmt_ready);
    if (chk_en) check_outputs();
    if (reset) begin
      model_reset();
      chk_en = 1'b1;
      return;
    end
    push = in_valid && q.size() < 2;
    fire = exp_ov && out_ready;
    m_err_v = 1'b0;
    load = 1'b0;
    if (fire) begin
      h = q.pop_front();
      w = h.wis;
      fired++;
      fired_pl.push_back(h.payload);
      code = 0;
      if (h.is_vec) begin
        if (!m_act[w]) begin
          ovf = h.lane >= MAX_LANES;
          bd  = h.lane != 0;
          m_vd[w]  = h.vd;
          m_cnt[w] = 1;
        end else begin
          ovf = h.lane >= MAX_LANES || m_cnt[w] + 1 > MAX_LANES;
          bd  = h.lane != m_exp[w] || h.vd != m_vd[w];
          m_cnt[w] = (m_cnt[w] < MAX_LANES) ? m_cnt[w] + 1 : MAX_LANES;
        end
        m_exp[w] = (h.lane + 1) % 16;
        code = ovf ? 3 : (bd ? 1 : 0);
        m_act[w] = !h.last;
        if (h.last) begin
          load = 1'b1;
          m_cmt.wis = w; m_cmt.vd = m_vd[w]; m_cmt.lanes = m_cnt[w];
        end
      end else if (m_act[w]) begin
        code = 2;
      end
      if (code != 0) begin
        m_err_v = 1'b1; m_err.code = code; m_err.wis = w;
        err_log.push_back(m_err);
        m_sticky = 1'b1;
      end
    end
    if (push) begin
      q.push_back(cur);
      void'(src.pop_front());
    end
    if (load) begin
      m_cmt_v = 1'b1;
      cmt_log.push_back(m_cmt);
    end else if (m_cmt_v && cmt_ready) begin
      m_cmt_v = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((src.size() > 0 || q.size() > 0 || m_cmt_v) && n < 500) begin
      step(); n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
    step(); step();
  endtask

  task automatic new_phase();
    cmt_log.delete(); err_log.delete(); fired_pl.delete(); fired = 0;
    in_pct = 100; or_pct = 100; cr_pct = 100;
  endtask

  task automatic chk_cmt(input string name, input int idx, input int w, input int vd, input int lanes);
    total++;
    if (idx >= cmt_log.size()) begin
      bad++;
      $display("FAIL %s: commit %0d missing, have %0d", name, idx, cmt_log.size());
    end else if (cmt_log[idx].wis != w || cmt_log[idx].vd != vd || cmt_log[idx].lanes != lanes) begin
      bad++;
      $display("FAIL %s: got wis=%0d vd=%0d lanes=%0d required wis=%0d vd=%0d lanes=%0d", name,
               cmt_log[idx].wis, cmt_log[idx].vd, cmt_log[idx].lanes, w, vd, lanes);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_in_ready"}, in_ready, 1'b1);
    chk({name, "_out_valid"}, out_valid, 1'b0);
    chk({name, "_cmt_valid"}, cmt_valid, 1'b0);
    chk({name, "_err_valid"}, err_valid, 1'b0);
    chk({name, "_err_sticky"}, err_sticky, 1'b0);
    chk({name, "_out_payload"}, out_payload, 256'd0);
    chk({name, "_cmt_lanes"}, cmt_lanes, 4'd0);
  endtask

  function automatic beat_t gen_beat();
    beat_t b;
    int w, r, lane;
    bit last;
    w = int'($urandom_range(NUM_WIS - 1));
    r = int'($urandom_range(99));
    if (r < 10) return sbeat(w);
    if (g_next[w] == 0) begin
      g_vd[w]  = int'($urandom_range(63));
      g_len[w] = int'($urandom_range(1, 10));
    end
    lane = g_next[w];
    if (r < 14) lane = int'($urandom_range(15));
    last = g_next[w] + 1 >= g_len[w];
    b = vbeat(w, (r >= 14 && r < 16) ? int'($urandom_range(63)) : g_vd[w], lane, last);
    g_next[w] = last ? 0 : g_next[w] + 1;
    return b;
  endfunction

  initial begin
    for (int i = 0; i < NUM_WIS; i++) begin g_next[i] = 0; g_len[i] = 1; g_vd[i] = 0; end
    model_reset();

    // reset state
    new_phase();
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    step();
    chk_reset_state("reset");

    // wis 1, vd 5, lanes 0..3
    new_phase();
    for (int i = 0; i < 4; i++) src.push_back(vbeat(1, 5, i, i == 3));
    drain("t1");
    chk("t1_ncmt", cmt_log.size(), 1);
    chk_cmt("t1_cmt", 0, 1, 5, 4);
    chk("t1_nerr", err_log.size(), 0);
    chk("t1_fired", fired, 4);

    // backpressure on out, then throughput recovery
    new_phase();
    for (int i = 0; i < 6; i++) begin
      beat_t b;
      b = sbeat(3); b.payload = 256'(i); src.push_back(b);
    end
    or_pct = 0;
    repeat (3) step();
    chk("t2_in_ready_full", in_ready, 1'b0);
    chk("t2_occupancy", q.size(), 2);
    or_pct = 100;
    repeat (6) step();
    chk("t2_fired", fired, 6);
    chk("t2_empty", q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      if (i < fired_pl.size()) chk("t2_order", fired_pl[i], 256'(i));
    end

    // bad lane in the middle
    new_phase();
    src.push_back(vbeat(0, 9, 0, 1'b0));
    src.push_back(vbeat(0, 9, 2, 1'b0));
    src.push_back(vbeat(0, 9, 3, 1'b1));
    drain("t3");
    chk("t3_nerr", err_log.size(), 1);
    if (err_log.size() > 0) begin
      chk("t3_err_code", err_log[0].code, 1);
      chk("t3_err_wis", err_log[0].wis, 0);
    end
    chk_cmt("t3_cmt", 0, 0, 9, 3);
    chk("t3_sticky", err_sticky, 1'b1);

    // scalar inside a sequence
    new_phase();
    src.push_back(vbeat(2, 7, 0, 1'b0));
    src.push_back(sbeat(2));
    src.push_back(vbeat(2, 7, 1, 1'b1));
    drain("t4");
    chk("t4_nerr", err_log.size(), 1);
    if (err_log.size() > 0) chk("t4_err_code", err_log[0].code, 2);
    chk_cmt("t4_cmt", 0, 2, 7, 2);
    chk("t4_fired", fired, 3);

    // commit backpressure holds the second last beat
    new_phase();
    cr_pct = 0;
    src.push_back(vbeat(0, 1, 0, 1'b1));
    src.push_back(vbeat(1, 2, 0, 1'b1));
    repeat (6) step();
    chk("t5_out_stall", out_valid, 1'b0);
    chk("t5_cmt_hold", cmt_valid, 1'b1);
    chk("t5_cmt_vd", cmt_vd, 6'd1);
    chk("t5_queued", q.size(), 1);
    cr_pct = 100;
    drain("t5");
    chk_cmt("t5_cmt0", 0, 0, 1, 1);
    chk_cmt("t5_cmt1", 1, 1, 2, 1);
    chk("t5_nerr", err_log.size(), 0);

    // reset mid-sequence
    new_phase();
    for (int i = 0; i < 4; i++) src.push_back(vbeat(3, 4, i, i == 3));
    begin
      int n;
      n = 0;
      while (fired < 2 && n < 20) begin step(); n++; end
      chk("t6_reached_lane1", fired >= 2, 1'b1);
    end
    src.delete();
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    step();
    chk_reset_state("t6_reset");
    new_phase();
    src.push_back(vbeat(3, 4, 0, 1'b0));
    src.push_back(vbeat(3, 4, 1, 1'b1));
    drain("t6");
    chk("t6_nerr", err_log.size(), 0);
    chk_cmt("t6_cmt", 0, 3, 4, 2);

    // random traffic with interleaved slots, errors and one reset
    new_phase();
    in_pct = 80; or_pct = 70; cr_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      while (src.size() < 2) src.push_back(gen_beat());
      rst_req = (c == 1500);
      if (rst_req) for (int i = 0; i < NUM_WIS; i++) g_next[i] = 0;
      step();
    end
    rst_req = 1'b0;
    in_pct = 100; or_pct = 100; cr_pct = 100;
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
